// File: rtl/dmem_axi_bridge_if.sv
// AXI4 single-beat bus bundle between the data-memory bridge and the SoC
// interconnect.
//   master modport: the bridge (drives AR/AW/W valids, R/B readies)
//   slave  modport: the interconnect side (drives readies, R data, B response)
// Channels: AR (arid/araddr/arlen/arsize/arburst/arvalid/arready)
//           R  (rdata/rresp/rvalid/rready)
//           AW (awid/awaddr/awlen/awsize/awburst/awvalid/awready)
//           W  (wdata/wstrb/wlast/wvalid/wready)
//           B  (bresp/bvalid/bready)
interface dmem_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dmem_axi_bridge.sv
// Data-memory request responder: turns the memory stage's word-aligned
// read/write requests into single-beat AXI4 transactions and stalls the
// pipeline until the transaction (or write-then-read pair) completes.
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   req_read_en/addr   read request from the memory stage
//   req_write_en/sel/addr/data  write request (sel = byte enables)
//   resp_read_data     last completed read word (unshifted)
//   stall_o            hold pipeline while a request is outstanding
//   bus_err_o          one-cycle pulse in DONE if RRESP/BRESP was not OKAY
//   axi                AXI4 master port (see dmem_axi_bridge_if)
module dmem_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read_en,
    input  logic [31:0] req_read_addr,
    input  logic        req_write_en,
    input  logic [3:0]  req_write_sel,
    input  logic [31:0] req_write_addr,
    input  logic [31:0] req_write_data,
    output logic [31:0] resp_read_data,
    output logic        stall_o,
    output logic        bus_err_o,
    dmem_axi_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        awvalid_reg, awvalid_next;
    logic        wvalid_reg, wvalid_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic        bready_reg, bready_next;
    logic        arvalid_reg, arvalid_next;
    logic        rready_reg, rready_next;
    logic        err_reg, err_next;
    logic [31:0] awaddr_reg, awaddr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [31:0] araddr_reg, araddr_next;
    logic [31:0] resp_read_data_reg, resp_read_data_next;

    logic wr_req;
    logic aw_fire;
    logic w_fire;

    // A write with no byte enabled is not a write at all.
    assign wr_req  = req_write_en && (req_write_sel != 4'b0000);
    assign aw_fire = awvalid_reg && axi.awready;
    assign w_fire  = wvalid_reg && axi.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            awvalid_reg        <= 1'b0;
            wvalid_reg         <= 1'b0;
            aw_done_reg        <= 1'b0;
            w_done_reg         <= 1'b0;
            bready_reg         <= 1'b0;
            arvalid_reg        <= 1'b0;
            rready_reg         <= 1'b0;
            err_reg            <= 1'b0;
            awaddr_reg         <= 32'h0;
            wdata_reg          <= 32'h0;
            wstrb_reg          <= 4'h0;
            araddr_reg         <= 32'h0;
            resp_read_data_reg <= 32'h0;
        end else begin
            state_reg          <= state_next;
            awvalid_reg        <= awvalid_next;
            wvalid_reg         <= wvalid_next;
            aw_done_reg        <= aw_done_next;
            w_done_reg         <= w_done_next;
            bready_reg         <= bready_next;
            arvalid_reg        <= arvalid_next;
            rready_reg         <= rready_next;
            err_reg            <= err_next;
            awaddr_reg         <= awaddr_next;
            wdata_reg          <= wdata_next;
            wstrb_reg          <= wstrb_next;
            araddr_reg         <= araddr_next;
            resp_read_data_reg <= resp_read_data_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        awvalid_next        = awvalid_reg;
        wvalid_next         = wvalid_reg;
        aw_done_next        = aw_done_reg;
        w_done_next         = w_done_reg;
        bready_next         = bready_reg;
        arvalid_next        = arvalid_reg;
        rready_next         = rready_reg;
        err_next            = err_reg;
        awaddr_next         = awaddr_reg;
        wdata_next          = wdata_reg;
        wstrb_next          = wstrb_reg;
        araddr_next         = araddr_reg;
        resp_read_data_next = resp_read_data_reg;

        case (state_reg)
            IDLE: begin
                // Writes go first; a pending read is picked up after B.
                if (wr_req) begin
                    state_next   = WR_ADDR;
                    awaddr_next  = req_write_addr;
                    wdata_next   = req_write_data;
                    wstrb_next   = req_write_sel;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else if (req_read_en) begin
                    state_next   = RD_ADDR;
                    araddr_next  = req_read_addr;
                    arvalid_next = 1'b1;
                end
            end

            WR_ADDR: begin
                // AW and W complete independently, in either order.
                if (aw_fire) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_fire) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    state_next  = WR_RESP;
                    bready_next = 1'b1;
                end
            end

            WR_RESP: begin
                if (bready_reg && axi.bvalid) begin
                    bready_next = 1'b0;
                    err_next    = err_reg || (axi.bresp != 2'b00);
                    if (req_read_en) begin
                        state_next   = RD_ADDR;
                        araddr_next  = req_read_addr;
                        arvalid_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            RD_ADDR: begin
                if (arvalid_reg && axi.arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rready_reg && axi.rvalid) begin
                    resp_read_data_next = axi.rdata;
                    err_next            = err_reg || (axi.rresp != 2'b00);
                    rready_next         = 1'b0;
                    state_next          = DONE;
                end
            end

            DONE: begin
                // The pipeline advances on this edge; the error pulse is
                // visible during this single cycle only.
                err_next     = 1'b0;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall drops in DONE so the pipeline can advance with the result.
    assign stall_o        = (state_reg != DONE) && (wr_req || req_read_en);
    assign bus_err_o      = (state_reg == DONE) && err_reg;
    assign resp_read_data = resp_read_data_reg;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_reg;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_reg;
    assign axi.rready  = rready_reg;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = awaddr_reg;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_reg;

    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wlast   = wvalid_reg;
    assign axi.wvalid  = wvalid_reg;

    assign axi.bready  = bready_reg;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Testbench for dmem_axi_bridge: directed cases followed by randomized
// read/write/pair transactions against an AXI slave with random wait states.
// Expected timing, memory contents and error pulses come from a transaction
// level model (cycle arithmetic + associative-array memory).
module tb_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read_en;
    logic [31:0] req_read_addr;
    logic        req_write_en;
    logic [3:0]  req_write_sel;
    logic [31:0] req_write_addr;
    logic [31:0] req_write_data;
    logic [31:0] resp_read_data;
    logic        stall_o;
    logic        bus_err_o;

    dmem_axi_bridge_if axi_bus();

    dmem_axi_bridge #(.AXI_ID(4'h1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_read_en    (req_read_en),
        .req_read_addr  (req_read_addr),
        .req_write_en   (req_write_en),
        .req_write_sel  (req_write_sel),
        .req_write_addr (req_write_addr),
        .req_write_data (req_write_data),
        .resp_read_data (resp_read_data),
        .stall_o        (stall_o),
        .bus_err_o      (bus_err_o),
        .axi            (axi_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory (model) and slave memory (bus side), same initial fill.
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] exp_rd;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return fill(a);
    endfunction

    // Slave state for the current transaction.
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int          aw_age, w_age, b_age, ar_age, r_age;
    logic [1:0]  bresp_drv, rresp_drv;
    logic        aw_got, w_got;
    logic [31:0] got_awaddr, got_wdata, got_araddr;
    logic [3:0]  got_wstrb;
    logic [31:0] cur_waddr, cur_wdata, cur_raddr;
    logic [3:0]  cur_sel;
    string       tname;

    task automatic slave_clear();
        aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
        aw_got = 1'b0; w_got = 1'b0;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = 2'b00;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rdata   = 32'h0;
    endtask

    // One cycle of the AXI slave: readies/valids driven from current outputs.
    task automatic slave_cycle();
        axi_bus.awready = axi_bus.awvalid && (aw_age == aw_wait);
        if (axi_bus.awvalid && !axi_bus.awready) aw_age++;
        if (axi_bus.awvalid && axi_bus.awready) begin
            got_awaddr = axi_bus.awaddr;
            aw_got = 1'b1;
            check({tname, " awaddr"}, axi_bus.awaddr, cur_waddr);
            check({tname, " aw fixed"}, {16'h0, axi_bus.awid, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst, 1'b0},
                  {16'h0, 4'h1, 8'd0, 3'b010, 2'b01, 1'b0});
        end
        axi_bus.wready = axi_bus.wvalid && (w_age == w_wait);
        if (axi_bus.wvalid && !axi_bus.wready) w_age++;
        if (axi_bus.wvalid && axi_bus.wready) begin
            got_wdata = axi_bus.wdata;
            got_wstrb = axi_bus.wstrb;
            w_got = 1'b1;
            check({tname, " wdata"}, axi_bus.wdata, cur_wdata);
            check({tname, " wstrb"}, 32'(axi_bus.wstrb), 32'(cur_sel));
            check({tname, " wlast"}, 32'(axi_bus.wlast), 32'd1);
        end
        axi_bus.bvalid = axi_bus.bready && (b_age == b_wait);
        axi_bus.bresp  = axi_bus.bvalid ? bresp_drv : 2'b00;
        if (axi_bus.bready && !axi_bus.bvalid) b_age++;
        if (axi_bus.bvalid && aw_got && w_got)
            slave_mem[got_awaddr] = merge(slave_rd(got_awaddr), got_wstrb, got_wdata);
        axi_bus.arready = axi_bus.arvalid && (ar_age == ar_wait);
        if (axi_bus.arvalid && !axi_bus.arready) ar_age++;
        if (axi_bus.arvalid && axi_bus.arready) begin
            got_araddr = axi_bus.araddr;
            check({tname, " araddr"}, axi_bus.araddr, cur_raddr);
            check({tname, " ar fixed"}, {16'h0, axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst, 1'b0},
                  {16'h0, 4'h1, 8'd0, 3'b010, 2'b01, 1'b0});
        end
        axi_bus.rvalid = axi_bus.rready && (r_age == r_wait);
        axi_bus.rresp  = axi_bus.rvalid ? rresp_drv : 2'b00;
        axi_bus.rdata  = axi_bus.rvalid ? slave_rd(got_araddr) : $urandom;
        if (axi_bus.rready && !axi_bus.rvalid) r_age++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_read_en = 1'b0; req_write_en = 1'b0;
        slave_clear();
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 32'h0;
        @(negedge clk);
    endtask

    // One request from the memory stage; entered and left at a falling edge.
    task automatic txn(input int tn, input logic we, input logic [3:0] sel, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic re, input logic [31:0] raddr,
                       input int aww, input int ww, input int bw, input int arw, input int rw,
                       input logic [1:0] bresp, input logic [1:0] rresp);
        logic        wr, rd, err;
        int          m, wlen, rlen, r0, lat, ncyc, fail0;
        logic [31:0] old_rd, new_rd;
        wr = we && (sel != 4'b0000);
        rd = re;
        m    = (aww > ww) ? aww : ww;
        wlen = wr ? m + bw + 2 : 0;
        rlen = rd ? arw + rw + 2 : 0;
        r0   = 1 + wlen;
        lat  = (wr || rd) ? 1 + wlen + rlen : 0;
        ncyc = (lat == 0) ? 4 : lat + 1;
        err  = (wr && bresp != 2'b00) || (rd && rresp != 2'b00);
        if (wr) ref_mem[waddr] = merge(ref_rd(waddr), sel, wdata);
        old_rd = exp_rd;
        new_rd = rd ? ref_rd(raddr) : exp_rd;
        fail0  = n_fail;

        req_write_en = we; req_write_sel = sel; req_write_addr = waddr; req_write_data = wdata;
        req_read_en = re; req_read_addr = raddr;
        cur_waddr = waddr; cur_wdata = wdata; cur_sel = sel; cur_raddr = raddr;
        aw_wait = aww; w_wait = ww; b_wait = bw; ar_wait = arw; r_wait = rw;
        bresp_drv = bresp; rresp_drv = rresp;
        slave_clear();

        for (int c = 0; c < ncyc; c++) begin
            #1;
            tname = $sformatf("t%0d c%0d", tn, c);
            check({tname, " stall"},   32'(stall_o),         32'(c < lat));
            check({tname, " awvalid"}, 32'(axi_bus.awvalid), 32'(wr && c >= 1 && c <= 1 + aww));
            check({tname, " wvalid"},  32'(axi_bus.wvalid),  32'(wr && c >= 1 && c <= 1 + ww));
            check({tname, " bready"},  32'(axi_bus.bready),  32'(wr && c >= 2 + m && c <= 2 + m + bw));
            check({tname, " arvalid"}, 32'(axi_bus.arvalid), 32'(rd && c >= r0 && c <= r0 + arw));
            check({tname, " rready"},  32'(axi_bus.rready),  32'(rd && c >= r0 + arw + 1 && c <= r0 + arw + 1 + rw));
            check({tname, " bus_err"}, 32'(bus_err_o),       32'(lat > 0 && c == lat && err));
            check({tname, " rdata"},   resp_read_data,       (lat > 0 && c == lat) ? new_rd : old_rd);
            slave_cycle();
            @(negedge clk);
        end
        exp_rd = new_rd;
        $display("txn %0d we=%0b sel=%04b wa=%08h re=%0b ra=%08h lat=%0d err=%0b rd=%08h",
                 tn, we, sel, waddr, re, raddr, lat, err, new_rd);
        if (n_fail != fail0) do_reset();
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        req_read_en = 1'b0; req_read_addr = 32'h0;
        req_write_en = 1'b0; req_write_sel = 4'h0; req_write_addr = 32'h0; req_write_data = 32'h0;
        tname = "reset";
        slave_clear();
        exp_rd = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset valids", {27'h0, axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 32'h0);
        check("reset addr",   axi_bus.araddr | axi_bus.awaddr, 32'h0);
        check("reset wdata",  axi_bus.wdata, 32'h0);
        check("reset wstrb",  32'(axi_bus.wstrb), 32'h0);
        check("reset rdata",  resp_read_data, 32'h0);
        check("reset err",    32'(bus_err_o), 32'h0);
        check("reset stall",  32'(stall_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        ref_mem[32'h1FC0_0010]   = 32'hDEAD_BEEF;
        slave_mem[32'h1FC0_0010] = 32'hDEAD_BEEF;
        txn(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h1FC0_0010, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        txn(2, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h1FC0_0010, 0, 0, 0, 3, 2, 2'b00, 2'b00);
        txn(3, 1'b1, 4'b0100, 32'h8000_0004, 32'h5A5A_5A5A, 1'b0, 32'h0, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        txn(4, 1'b1, 4'b1111, 32'h8000_0008, 32'h1234_5678, 1'b1, 32'h8000_0008, 0, 1, 0, 1, 0, 2'b00, 2'b00);
        txn(5, 1'b1, 4'b0011, 32'h8000_000C, 32'hCAFE_F00D, 1'b0, 32'h0, 0, 0, 2, 0, 0, 2'b10, 2'b00);
        txn(6, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0004, 0, 0, 0, 0, 1, 2'b00, 2'b11);

        // Reset while waiting for read data.
        tname = "rst";
        req_read_en = 1'b1; req_read_addr = 32'h8000_0010; req_write_en = 1'b0;
        cur_raddr = 32'h8000_0010;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 8;
        bresp_drv = 2'b00; rresp_drv = 2'b00;
        slave_clear();
        for (int c = 0; c < 3; c++) begin
            #1;
            slave_cycle();
            @(negedge clk);
        end
        #1;
        check("rst pre rready", 32'(axi_bus.rready), 32'd1);
        rst = 1'b1;
        slave_clear();
        @(negedge clk);
        #1;
        check("rst rready",  32'(axi_bus.rready), 32'd0);
        check("rst arvalid", 32'(axi_bus.arvalid), 32'd0);
        check("rst stall",   32'(stall_o), 32'd1);
        check("rst rdata",   resp_read_data, 32'h0);
        rst = 1'b0;
        req_read_en = 1'b0;
        exp_rd = 32'h0;
        #1;
        check("rst stall idle", 32'(stall_o), 32'd0);
        @(negedge clk);
        txn(7, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0010, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        txn(8, 1'b1, 4'b0000, 32'h8000_0014, 32'hFFFF_FFFF, 1'b0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // Randomized traffic over a small address window to get read-after-write hits.
        for (int t = 9; t < 80; t++) begin
            int          kind;
            logic [3:0]  sel;
            logic [31:0] wa, ra;
            kind = $urandom_range(0, 3);
            sel  = 4'($urandom_range(0, 15));
            a    = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            wa   = a;
            ra   = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 1) == 1) ra = wa;
            txn(t, kind != 0, sel, wa, $urandom, kind != 1, ra,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
